// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch / prefetch slice.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned INST_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Byte size of one instruction word and the number of PC bits below it.
  localparam int unsigned INST_BYTES = INST_W_DEF / 8;
  localparam int unsigned ALIGN_BITS = $clog2(INST_BYTES);

  // One prefetch queue entry at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } fetch_entry_t;

  // Number of low PC bits that address bytes inside one instruction.
  function automatic int unsigned align_bits_of(input int unsigned inst_w);
    return $clog2(inst_w / 8);
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface fetch_prefetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch queue holding {pc, inst} pairs; head is read straight
// from the storage registers so it is a registered output.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [ADDR_W-1:0]        i_push_pc,
  input  logic [INST_W-1:0]        i_push_inst,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [ADDR_W-1:0]        o_head_pc,
  output logic [INST_W-1:0]        o_head_inst,
  output logic                     o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;
  entry_t           w_head;

  assign w_do_push = i_push && !i_flush;
  assign w_do_pop  = i_pop && !i_flush && (r_count != CNT_W'(0));
  assign w_head    = r_mem[r_rd_ptr];

  // Entry storage: cleared on reset so the head reads zero until first push.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '{pc: {ADDR_W{1'b0}}, inst: {INST_W{1'b0}}};
      end
    end else if (w_do_push) begin
      r_mem[r_wr_ptr] <= '{pc: i_push_pc, inst: i_push_inst};
    end
  end

  // Pointers wrap naturally at DEPTH; a flush empties the queue outright.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else if (i_flush) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_count     = r_count;
  assign o_head_pc   = w_head.pc;
  assign o_head_inst = w_head.inst;
  assign o_empty     = (r_count == CNT_W'(0));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: runs the PC ahead of decode, keeps at most DEPTH words in
// flight or queued, and discards in-flight responses after a redirect.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       INST_W   = INST_W_DEF,
  parameter int unsigned       DEPTH    = DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_redirect,
  input  logic [ADDR_W-1:0]    i_redirect_pc,
  fetch_prefetch_unit_if.master imem,
  output logic                 o_inst_valid,
  output logic [INST_W-1:0]    o_inst,
  output logic [ADDR_W-1:0]    o_inst_pc,
  input  logic                 i_inst_ready
);

  localparam int unsigned       L_ALIGN_BITS = align_bits_of(INST_W);
  localparam logic [ADDR_W-1:0] L_STEP       = ADDR_W'(INST_W / 8);
  localparam logic [ADDR_W-1:0] L_ALIGN_MASK = ~((ADDR_W'(1) << L_ALIGN_BITS) - ADDR_W'(1));
  localparam int unsigned       CNT_W        = $clog2(DEPTH) + 1;
  localparam int unsigned       SUM_W        = CNT_W + 1;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop;

  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_empty;
  logic [SUM_W-1:0]  w_credit_sum;
  logic              w_req;
  logic              w_accept;
  logic              w_resp;
  logic              w_drop_resp;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_redirect_pc;

  // Request credit: queued plus in-flight words may not exceed DEPTH; same-cycle pops are not credited.
  always_comb begin
    w_credit_sum = SUM_W'(w_fifo_count) + SUM_W'(r_outstanding);
    w_req        = !reset && !i_redirect && (w_credit_sum < SUM_W'(DEPTH));
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_fetch_pc;

  assign w_accept      = w_req && imem.imem_ready;
  assign w_resp        = imem.imem_rvalid;
  assign w_drop_resp   = w_resp && (r_drop != CNT_W'(0));
  assign w_push        = w_resp && !w_drop_resp && !i_redirect;
  assign w_pop         = !w_fifo_empty && i_inst_ready && !i_redirect;
  assign w_redirect_pc = i_redirect_pc & L_ALIGN_MASK;

  // Request and response PCs: redirect reloads both, otherwise each steps on its own event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
    end else if (i_redirect) begin
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + L_STEP;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + L_STEP;
      end
    end
  end

  // In-flight tracking: on redirect every still-pending response becomes one to discard.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_outstanding <= CNT_W'(0);
      r_drop        <= CNT_W'(0);
    end else if (i_redirect) begin
      r_outstanding <= r_outstanding - CNT_W'(w_resp);
      r_drop        <= r_outstanding - CNT_W'(w_resp);
    end else begin
      r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_resp);
      if (w_drop_resp) begin
        r_drop <= r_drop - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_pc   (r_resp_pc),
    .i_push_inst (imem.imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (i_redirect),
    .o_count     (w_fifo_count),
    .o_head_pc   (o_inst_pc),
    .o_head_inst (o_inst),
    .o_empty     (w_fifo_empty)
  );

  assign o_inst_valid = !w_fifo_empty;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order variable-latency memory model.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned pops     = 0;
  logic [31:0] exp_pc   = 32'h0;
  logic        sb_on    = 1'b0;
  fetch_entry_t head_obs;

  // memory model state
  typedef struct { logic [31:0] addr; int unsigned due; } mreq_t;
  mreq_t       mq[$];
  int unsigned lat      = 1;
  int unsigned cyc      = 0;
  int unsigned n_accept = 0;

  fetch_prefetch_unit_if #(.ADDR_W(32), .INST_W(32)) bus ();

  fetch_prefetch_unit #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .imem          (bus),
    .o_inst_valid  (inst_valid),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .i_inst_ready  (inst_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // In-order memory: accepted at cycle A, answered in cycle A+lat.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
      cyc             <= 0;
      n_accept        <= 0;
    end else begin
      if (bus.imem_req && bus.imem_ready) begin
        mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
        n_accept <= n_accept + 1;
      end
      cyc <= cyc + 1;
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.imem_rvalid <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Score the pop of the current cycle (inputs already final), then advance to the next negedge.
  task automatic tick();
    if (sb_on && inst_valid && inst_ready && !redirect) begin
      head_obs.pc   = inst_pc;
      head_obs.inst = inst;
      check_eq("pop_pc", 64'(head_obs.pc), 64'(exp_pc));
      check_eq("pop_inst", 64'(head_obs.inst), 64'(mem_word(exp_pc)));
      exp_pc = exp_pc + 32'(INST_BYTES);
      pops++;
    end
    @(negedge clock);
  endtask

  task automatic apply_reset();
    sb_on = 1'b0;
    redirect = 1'b0;
    bus.imem_ready = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_pc = 32'h0;
    pops = 0;
    sb_on = 1'b1;
  endtask

  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        found;

    bus.imem_ready = 1'b1;
    #2 reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    // reset state
    check_eq("rst_inst_valid", 64'(inst_valid), 64'(1'b0));
    check_eq("rst_imem_req", 64'(bus.imem_req), 64'(1'b0));
    check_eq("rst_inst", 64'(inst), 64'h0);
    check_eq("rst_inst_pc", 64'(inst_pc), 64'h0);

    // T1: free run, L=1
    lat = 1; inst_ready = 1'b1;
    reset = 1'b0; exp_pc = 32'h0; pops = 0; sb_on = 1'b1;
    #1;
    check_eq("t1_req_after_release", 64'(bus.imem_req), 64'(1'b1));
    check_eq("t1_first_addr", 64'(bus.imem_addr), 64'h0);
    tick();
    check_eq("t1_valid_cycle1", 64'(inst_valid), 64'(1'b0));
    tick();
    check_eq("t1_valid_cycle2", 64'(inst_valid), 64'(1'b1));
    for (int i = 0; i < 10; i++) begin
      check_eq("t1_throughput", 64'(inst_valid), 64'(1'b1));
      tick();
    end
    check_eq("t1_pops", 64'(pops), 64'd10);

    // T2: decode stalled, L=2
    lat = 2; inst_ready = 1'b0;
    apply_reset();
    repeat (10) tick();
    check_eq("t2_req_low_full", 64'(bus.imem_req), 64'(1'b0));
    check_eq("t2_accepts", 64'(n_accept), 64'd4);
    check_eq("t2_head_valid", 64'(inst_valid), 64'(1'b1));
    check_eq("t2_head_pc", 64'(inst_pc), 64'h0);
    inst_ready = 1'b1;
    repeat (14) tick();
    check_eq("t2_drained", 64'(pops >= 8), 64'(1'b1));

    // T3: redirect to 0x100 with 3 outstanding, L=3
    lat = 3; inst_ready = 1'b1;
    apply_reset();
    repeat (3) tick();
    check_eq("t3_accepts_before", 64'(n_accept), 64'd3);
    redirect = 1'b1; redirect_pc = 32'h100; exp_pc = 32'h100;
    #1;
    check_eq("t3_req_low_redirect", 64'(bus.imem_req), 64'(1'b0));
    tick();
    redirect = 1'b0;
    check_eq("t3_valid_after_redirect", 64'(inst_valid), 64'(1'b0));
    #1;
    check_eq("t3_req_target", 64'(bus.imem_req), 64'(1'b1));
    check_eq("t3_addr_target", 64'(bus.imem_addr), 64'h100);
    repeat (12) tick();
    check_eq("t3_pops", 64'(pops >= 2), 64'(1'b1));

    // T4: redirect to 0x203 alongside a response and a pop, L=2
    lat = 2; inst_ready = 1'b1;
    apply_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (inst_valid && bus.imem_rvalid) found = 1'b1;
      else tick();
    end
    check_eq("t4_setup", 64'(found), 64'(1'b1));
    redirect = 1'b1; redirect_pc = 32'h203;
    exp_pc = 32'h203 & ~((32'd1 << ALIGN_BITS) - 32'd1);
    tick();
    redirect = 1'b0;
    check_eq("t4_queue_empty", 64'(inst_valid), 64'(1'b0));
    #1;
    check_eq("t4_addr_aligned", 64'(bus.imem_addr), 64'h200);
    pops = 0;
    repeat (12) tick();
    check_eq("t4_pops", 64'(pops >= 3), 64'(1'b1));

    // T5: wrap from 0xFFFFFFF8 with random ready, L=1
    lat = 1; inst_ready = 1'b1;
    apply_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; exp_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    prev_stall = 1'b0; prev_addr = 32'h0;
    for (int i = 0; i < 40; i++) begin
      bus.imem_ready = (i % 5 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) check_eq("t5_addr_stable", 64'(bus.imem_addr), 64'(prev_addr));
      prev_stall = bus.imem_req && !bus.imem_ready;
      prev_addr  = bus.imem_addr;
      tick();
    end
    bus.imem_ready = 1'b1;
    check_eq("t5_wrapped", 64'(pops >= 4), 64'(1'b1));

    // T6: reset mid-stream with entries queued
    lat = 1; inst_ready = 1'b0;
    apply_reset();
    repeat (6) tick();
    check_eq("t6_queued", 64'(inst_valid), 64'(1'b1));
    sb_on = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("t6_valid_in_reset", 64'(inst_valid), 64'(1'b0));
    check_eq("t6_req_in_reset", 64'(bus.imem_req), 64'(1'b0));
    check_eq("t6_inst_pc_in_reset", 64'(inst_pc), 64'h0);
    @(negedge clock);
    reset = 1'b0; exp_pc = 32'h0; pops = 0; sb_on = 1'b1; inst_ready = 1'b1;
    #1;
    check_eq("t6_restart_req", 64'(bus.imem_req), 64'(1'b1));
    check_eq("t6_restart_addr", 64'(bus.imem_addr), 64'h0);
    repeat (10) tick();
    check_eq("t6_pops", 64'(pops >= 5), 64'(1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
